// File: rtl/btn_led_ctrl.sv
// rtl/btn_led_ctrl.sv - debounced four-button LED controller with toggle and chase modes
module btn_led_ctrl #(
    parameter int DEBOUNCE_CYC = 33000,
    parameter int LONG_CYC     = 3300000,
    parameter int STEP_CYC     = 825000
) (
    input  logic CLK,
    input  logic RST,
    input  logic BTN1,
    input  logic BTN2,
    input  logic BTN3,
    input  logic BTN4,
    output logic LED1,
    output logic LED2,
    output logic LED3,
    output logic LED4,
    output logic MODE
);

    localparam int DW = $clog2(DEBOUNCE_CYC + 1);
    localparam int HW = $clog2(LONG_CYC + 1);
    localparam int SW = $clog2(STEP_CYC + 1);
    localparam logic [DW-1:0] DB_LAST   = DW'(DEBOUNCE_CYC - 1);
    localparam logic [HW-1:0] HOLD_MAX  = HW'(LONG_CYC);
    localparam logic [SW-1:0] STEP_LAST = SW'(STEP_CYC - 1);

    typedef enum logic {
        S_TOGGLE = 1'b0,
        S_CHASE  = 1'b1
    } state_t;

    logic [3:0]    raw;
    logic [3:0]    sync1;
    logic [3:0]    sync2;
    logic [3:0]    deb;
    logic [3:0]    deb_q;
    logic [DW-1:0] db_cnt [4];

    logic [2:0]    press;
    logic          rel4;
    logic [HW-1:0] hold;
    logic          arm;
    logic          long_ev;

    state_t        state;
    logic [3:0]    leds;
    logic [3:0]    saved;
    logic [3:0]    pattern;
    logic [3:0]    next_pat;
    logic          dir_down;
    logic          paused;
    logic [SW-1:0] step;

    assign raw = {BTN4, BTN3, BTN2, BTN1};

    // Two-flop synchroniser followed by a per-button disagreement counter.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            sync1 <= '0;
            sync2 <= '0;
            deb   <= '0;
            deb_q <= '0;
            for (int i = 0; i < 4; i++) begin
                db_cnt[i] <= '0;
            end
        end else begin
            sync1 <= raw;
            sync2 <= sync1;
            deb_q <= deb;
            for (int i = 0; i < 4; i++) begin
                if (sync2[i] == deb[i]) begin
                    db_cnt[i] <= '0;
                end else if (db_cnt[i] == DB_LAST) begin
                    deb[i]    <= sync2[i];
                    db_cnt[i] <= '0;
                end else begin
                    db_cnt[i] <= db_cnt[i] + 1'b1;
                end
            end
        end
    end

    assign press = deb[2:0] & ~deb_q[2:0];
    assign rel4  = deb_q[3] & ~deb[3];

    // Arm keeps a single hold from producing more than one long event.
    assign long_ev = arm && (hold == HOLD_MAX);

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            hold <= '0;
            arm  <= 1'b1;
        end else begin
            if (!deb[3]) begin
                hold <= '0;
            end else if (hold != HOLD_MAX) begin
                hold <= hold + 1'b1;
            end
            if (long_ev) begin
                arm <= 1'b0;
            end else if (rel4) begin
                arm <= 1'b1;
            end
        end
    end

    assign next_pat = dir_down ? {pattern[0], pattern[3:1]}
                               : {pattern[2:0], pattern[3]};

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state    <= S_TOGGLE;
            leds     <= '0;
            saved    <= '0;
            pattern  <= 4'b0001;
            dir_down <= 1'b0;
            paused   <= 1'b0;
            step     <= '0;
        end else begin
            case (state)
                S_TOGGLE: begin
                    if (long_ev) begin
                        saved    <= leds;
                        pattern  <= 4'b0001;
                        leds     <= 4'b0001;
                        dir_down <= 1'b0;
                        paused   <= 1'b0;
                        step     <= '0;
                        state    <= S_CHASE;
                    end else begin
                        // A release that ended a long hold leaves arm low, so no toggle.
                        leds <= leds ^ {rel4 & arm, press};
                    end
                end
                S_CHASE: begin
                    if (long_ev) begin
                        leds  <= saved;
                        state <= S_TOGGLE;
                    end else begin
                        if (press[0]) begin
                            dir_down <= ~dir_down;
                        end
                        if (press[1]) begin
                            paused <= ~paused;
                        end
                        if (!paused) begin
                            if (step == STEP_LAST) begin
                                step    <= '0;
                                pattern <= next_pat;
                                leds    <= next_pat;
                            end else begin
                                step <= step + 1'b1;
                            end
                        end
                    end
                end
                default: state <= S_TOGGLE;
            endcase
        end
    end

    assign {LED4, LED3, LED2, LED1} = leds;
    assign MODE = (state == S_CHASE);

endmodule

// File: tb/tb_btn_led_ctrl.sv
// tb/tb_btn_led_ctrl.sv - scoreboard bench for btn_led_ctrl with short debounce/hold/step timings
module tb_btn_led_ctrl;

    logic CLK;
    logic RST;
    logic BTN1, BTN2, BTN3, BTN4;
    logic LED1, LED2, LED3, LED4;
    logic MODE;
    logic [4:0] obs;

    int n_cmp;
    int n_bad;

    int         sb_cyc [$];
    logic [4:0] sb_val [$];
    string      sb_tag [$];

    btn_led_ctrl #(
        .DEBOUNCE_CYC(4),
        .LONG_CYC    (20),
        .STEP_CYC    (8)
    ) dut (
        .CLK (CLK),
        .RST (RST),
        .BTN1(BTN1),
        .BTN2(BTN2),
        .BTN3(BTN3),
        .BTN4(BTN4),
        .LED1(LED1),
        .LED2(LED2),
        .LED3(LED3),
        .LED4(LED4),
        .MODE(MODE)
    );

    assign obs = {MODE, LED4, LED3, LED2, LED1};

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic expect_at(input int c, input logic [4:0] v, input string t);
        sb_cyc.push_back(c);
        sb_val.push_back(v);
        sb_tag.push_back(t);
    endtask

    task automatic test_reset;
        logic [4:0] ev;
        string tg;
        int ec;
        @(negedge CLK);
        @(negedge CLK);
        expect_at(0, 5'b00000, "reset_held");
        ec = sb_cyc.pop_front(); ev = sb_val.pop_front(); tg = sb_tag.pop_front();
        n_cmp++;
        if (obs !== ev) begin n_bad++; $display("FAIL %s: obs=%b expected=%b", tg, obs, ev); end
        RST = 1'b0;
        @(negedge CLK);
        expect_at(1, 5'b00000, "reset_released");
        ec = sb_cyc.pop_front(); ev = sb_val.pop_front(); tg = sb_tag.pop_front();
        n_cmp++;
        if (obs !== ev) begin n_bad++; $display("FAIL %s: obs=%b expected=%b", tg, obs, ev); end
    endtask

    task automatic test_toggle;
        logic [4:0] ev;
        string tg;
        int ec;
        expect_at(6,  5'b00000, "t1_before_latency");
        expect_at(7,  5'b00001, "t1_led1_on");
        expect_at(18, 5'b00001, "t1_release_no_effect");
        expect_at(26, 5'b00001, "t1_second_before");
        expect_at(27, 5'b00000, "t1_led1_off");
        expect_at(40, 5'b00000, "t1_others_zero");
        BTN1 = 1'b1;
        for (int i = 1; i <= 40; i++) begin
            @(negedge CLK);
            while (sb_cyc.size() > 0 && sb_cyc[0] == i) begin
                ec = sb_cyc.pop_front(); ev = sb_val.pop_front(); tg = sb_tag.pop_front();
                n_cmp++;
                if (obs !== ev) begin n_bad++; $display("FAIL %s: obs=%b expected=%b", tg, obs, ev); end
            end
            if (i == 10) BTN1 = 1'b0;
            if (i == 20) BTN1 = 1'b1;
            if (i == 30) BTN1 = 1'b0;
        end
        if (sb_cyc.size() != 0) begin
            n_cmp++; n_bad++;
            $display("FAIL t1_pending: left=%0d expected=0", sb_cyc.size());
            sb_cyc.delete(); sb_val.delete(); sb_tag.delete();
        end
    endtask

    task automatic test_bounce;
        logic [4:0] ev;
        string tg;
        int ec;
        expect_at(10, 5'b00000, "t2_bounce_rejected");
        expect_at(19, 5'b00000, "t2_still_rejected");
        expect_at(26, 5'b00000, "t2_stable_before");
        expect_at(27, 5'b00010, "t2_led2_on");
        expect_at(40, 5'b00010, "t2_release_no_effect");
        BTN2 = 1'b1;
        for (int i = 1; i <= 40; i++) begin
            @(negedge CLK);
            while (sb_cyc.size() > 0 && sb_cyc[0] == i) begin
                ec = sb_cyc.pop_front(); ev = sb_val.pop_front(); tg = sb_tag.pop_front();
                n_cmp++;
                if (obs !== ev) begin n_bad++; $display("FAIL %s: obs=%b expected=%b", tg, obs, ev); end
            end
            if (i == 2)  BTN2 = 1'b0;
            if (i == 4)  BTN2 = 1'b1;
            if (i == 6)  BTN2 = 1'b0;
            if (i == 20) BTN2 = 1'b1;
            if (i == 30) BTN2 = 1'b0;
        end
        if (sb_cyc.size() != 0) begin
            n_cmp++; n_bad++;
            $display("FAIL t2_pending: left=%0d expected=0", sb_cyc.size());
            sb_cyc.delete(); sb_val.delete(); sb_tag.delete();
        end
    endtask

    task automatic test_simultaneous;
        logic [4:0] ev;
        string tg;
        int ec;
        expect_at(6,  5'b00010, "ts_before");
        expect_at(7,  5'b00101, "ts_three_toggles");
        expect_at(20, 5'b00101, "ts_after_release");
        BTN1 = 1'b1; BTN2 = 1'b1; BTN3 = 1'b1;
        for (int i = 1; i <= 20; i++) begin
            @(negedge CLK);
            while (sb_cyc.size() > 0 && sb_cyc[0] == i) begin
                ec = sb_cyc.pop_front(); ev = sb_val.pop_front(); tg = sb_tag.pop_front();
                n_cmp++;
                if (obs !== ev) begin n_bad++; $display("FAIL %s: obs=%b expected=%b", tg, obs, ev); end
            end
            if (i == 10) begin BTN1 = 1'b0; BTN2 = 1'b0; BTN3 = 1'b0; end
        end
        if (sb_cyc.size() != 0) begin
            n_cmp++; n_bad++;
            $display("FAIL ts_pending: left=%0d expected=0", sb_cyc.size());
            sb_cyc.delete(); sb_val.delete(); sb_tag.delete();
        end
    endtask

    task automatic test_enter_chase;
        logic [4:0] ev;
        string tg;
        int ec;
        expect_at(26, 5'b00101, "t3_before_long");
        expect_at(27, 5'b10001, "t3_chase_entry");
        expect_at(34, 5'b10001, "t3_step_boundary");
        expect_at(35, 5'b10010, "t3_step1");
        expect_at(43, 5'b10100, "t3_step2_release_ignored");
        expect_at(51, 5'b11000, "t3_step3");
        expect_at(59, 5'b10001, "t3_wrap_up");
        BTN4 = 1'b1;
        for (int i = 1; i <= 62; i++) begin
            @(negedge CLK);
            while (sb_cyc.size() > 0 && sb_cyc[0] == i) begin
                ec = sb_cyc.pop_front(); ev = sb_val.pop_front(); tg = sb_tag.pop_front();
                n_cmp++;
                if (obs !== ev) begin n_bad++; $display("FAIL %s: obs=%b expected=%b", tg, obs, ev); end
            end
            if (i == 36) BTN4 = 1'b0;
        end
        if (sb_cyc.size() != 0) begin
            n_cmp++; n_bad++;
            $display("FAIL t3_pending: left=%0d expected=0", sb_cyc.size());
            sb_cyc.delete(); sb_val.delete(); sb_tag.delete();
        end
    endtask

    task automatic test_chase_controls;
        logic [4:0] ev;
        string tg;
        int ec;
        expect_at(5,   5'b10010, "t4_step_0010");
        expect_at(13,  5'b10100, "t4_step_0100");
        expect_at(20,  5'b10100, "t4_dir_flip_no_step");
        expect_at(21,  5'b10010, "t4_down_0010");
        expect_at(29,  5'b10001, "t4_down_0001");
        expect_at(37,  5'b11000, "t4_down_wrap_1000");
        expect_at(45,  5'b10100, "t4_down_0100");
        expect_at(60,  5'b10100, "t4_paused_a");
        expect_at(87,  5'b10100, "t4_paused_b");
        expect_at(99,  5'b10100, "t4_resume_before");
        expect_at(100, 5'b10010, "t4_resume_step");
        for (int i = 1; i <= 104; i++) begin
            @(negedge CLK);
            while (sb_cyc.size() > 0 && sb_cyc[0] == i) begin
                ec = sb_cyc.pop_front(); ev = sb_val.pop_front(); tg = sb_tag.pop_front();
                n_cmp++;
                if (obs !== ev) begin n_bad++; $display("FAIL %s: obs=%b expected=%b", tg, obs, ev); end
            end
            if (i == 13) BTN1 = 1'b1;
            if (i == 23) BTN1 = 1'b0;
            if (i == 40) BTN2 = 1'b1;
            if (i == 50) BTN2 = 1'b0;
            if (i == 87) BTN2 = 1'b1;
            if (i == 97) BTN2 = 1'b0;
        end
        if (sb_cyc.size() != 0) begin
            n_cmp++; n_bad++;
            $display("FAIL t4_pending: left=%0d expected=0", sb_cyc.size());
            sb_cyc.delete(); sb_val.delete(); sb_tag.delete();
        end
    endtask

    task automatic test_exit_chase;
        logic [4:0] ev;
        string tg;
        int ec;
        expect_at(4,  5'b10001, "t5_down_0001");
        expect_at(12, 5'b11000, "t5_down_1000");
        expect_at(20, 5'b10100, "t5_down_0100");
        expect_at(26, 5'b10100, "t5_before_long");
        expect_at(27, 5'b00101, "t5_restored");
        expect_at(38, 5'b00101, "t5_long_release_no_toggle");
        expect_at(62, 5'b00101, "t5_short_before");
        expect_at(63, 5'b01101, "t5_short_toggles_led4");
        expect_at(70, 5'b01101, "t5_settled");
        BTN4 = 1'b1;
        for (int i = 1; i <= 70; i++) begin
            @(negedge CLK);
            while (sb_cyc.size() > 0 && sb_cyc[0] == i) begin
                ec = sb_cyc.pop_front(); ev = sb_val.pop_front(); tg = sb_tag.pop_front();
                n_cmp++;
                if (obs !== ev) begin n_bad++; $display("FAIL %s: obs=%b expected=%b", tg, obs, ev); end
            end
            if (i == 31) BTN4 = 1'b0;
            if (i == 46) BTN4 = 1'b1;
            if (i == 56) BTN4 = 1'b0;
        end
        if (sb_cyc.size() != 0) begin
            n_cmp++; n_bad++;
            $display("FAIL t5_pending: left=%0d expected=0", sb_cyc.size());
            sb_cyc.delete(); sb_val.delete(); sb_tag.delete();
        end
    endtask

    task automatic test_async_reset;
        logic [4:0] ev;
        string tg;
        int ec;
        expect_at(27, 5'b10001, "t6_chase_again");
        BTN4 = 1'b1;
        for (int i = 1; i <= 32; i++) begin
            @(negedge CLK);
            while (sb_cyc.size() > 0 && sb_cyc[0] == i) begin
                ec = sb_cyc.pop_front(); ev = sb_val.pop_front(); tg = sb_tag.pop_front();
                n_cmp++;
                if (obs !== ev) begin n_bad++; $display("FAIL %s: obs=%b expected=%b", tg, obs, ev); end
            end
            if (i == 28) BTN1 = 1'b1;
        end
        // Assert between clock edges so only the asynchronous path can clear the outputs.
        #2;
        RST = 1'b1;
        #1;
        expect_at(0, 5'b00000, "t6_async_clear");
        ec = sb_cyc.pop_front(); ev = sb_val.pop_front(); tg = sb_tag.pop_front();
        n_cmp++;
        if (obs !== ev) begin n_bad++; $display("FAIL %s: obs=%b expected=%b", tg, obs, ev); end
        BTN1 = 1'b0;
        BTN4 = 1'b0;
        @(negedge CLK);
        expect_at(0, 5'b00000, "t6_held_in_reset");
        ec = sb_cyc.pop_front(); ev = sb_val.pop_front(); tg = sb_tag.pop_front();
        n_cmp++;
        if (obs !== ev) begin n_bad++; $display("FAIL %s: obs=%b expected=%b", tg, obs, ev); end
        RST = 1'b0;
        expect_at(10, 5'b00000, "t6_idle_after_reset");
        expect_at(16, 5'b00000, "t6_post_before");
        expect_at(17, 5'b00001, "t6_post_led1_on");
        expect_at(30, 5'b00001, "t6_post_settled");
        for (int i = 1; i <= 30; i++) begin
            @(negedge CLK);
            while (sb_cyc.size() > 0 && sb_cyc[0] == i) begin
                ec = sb_cyc.pop_front(); ev = sb_val.pop_front(); tg = sb_tag.pop_front();
                n_cmp++;
                if (obs !== ev) begin n_bad++; $display("FAIL %s: obs=%b expected=%b", tg, obs, ev); end
            end
            if (i == 10) BTN1 = 1'b1;
            if (i == 20) BTN1 = 1'b0;
        end
        if (sb_cyc.size() != 0) begin
            n_cmp++; n_bad++;
            $display("FAIL t6_pending: left=%0d expected=0", sb_cyc.size());
            sb_cyc.delete(); sb_val.delete(); sb_tag.delete();
        end
    endtask

    initial begin
        n_cmp = 0;
        n_bad = 0;
        RST  = 1'b1;
        BTN1 = 1'b0;
        BTN2 = 1'b0;
        BTN3 = 1'b0;
        BTN4 = 1'b0;
        test_reset();
        test_toggle();
        test_bounce();
        test_simultaneous();
        test_enter_chase();
        test_chase_controls();
        test_exit_chase();
        test_async_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: time=%0t limit=100000", $time);
        $fatal(1);
    end

endmodule
